// File: rtl/keypad_scanner.sv
// Matrix keypad scanner: drives one column at a time, debounces whole scan frames and
// reports press, release, multi-key and optional auto-repeat events with a binary key code.
module keypad_scanner #(
  parameter int N_ROWS       = 4,
  parameter int N_COLS       = 4,
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE     = 4,
  parameter bit ACTIVE_LOW   = 1'b1,
  parameter bit REPEAT_EN    = 1'b0,
  parameter int REPEAT_DELAY = 32,
  parameter int REPEAT_RATE  = 8,
  localparam int CW = (N_ROWS * N_COLS > 1) ? $clog2(N_ROWS * N_COLS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_ROWS-1:0] rows,
  output logic [N_COLS-1:0] cols,
  output logic [CW-1:0]     key_code,
  output logic              key_valid,
  output logic              key_release,
  output logic              key_held,
  output logic              key_multi
);

  localparam int DW   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int COLW = $clog2(N_COLS);
  localparam int MW   = $clog2(DEBOUNCE + 1);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW   = $clog2(RMAX + 1);

  typedef enum logic [1:0] {K_NONE, K_SINGLE, K_MULTI} kind_e;

  typedef struct packed {
    kind_e           kind;
    logic [CW-1:0]   code;
  } result_t;

  logic [N_ROWS-1:0] sync1, sync2, hits;
  logic [DW-1:0]     div;
  logic [COLW-1:0]   col;
  logic              sample, frame_end;

  result_t           acc, merged, cand, cand_d;
  logic [MW-1:0]     match_cnt, match_d;
  logic              same, differs, accept;

  kind_e             col_kind;
  logic [CW-1:0]     col_code;

  kind_e             state, state_d;
  logic [CW-1:0]     code_q, code_d;
  logic              valid_q, valid_d, release_q, release_d;
  logic [RW-1:0]     rpt, rpt_d;
  logic              rpt_phase, rpt_phase_d;

  // Everything downstream of the synchroniser sees a pressed key as 1.
  assign hits      = ACTIVE_LOW ? ~sync2 : sync2;
  assign sample    = (div == DW'(SCAN_DIV - 1));
  assign frame_end = sample && (col == COLW'(N_COLS - 1));

  // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    col_kind = K_NONE;
    col_code = '0;
    // Walking rows downwards leaves the lowest pressed row's code behind.
    for (int r = N_ROWS - 1; r >= 0; r--) begin
      if (hits[r]) begin
        col_kind = (col_kind == K_NONE) ? K_SINGLE : K_MULTI;
        col_code = CW'(r * N_COLS) + CW'(col);
      end
    end

    merged = acc;
    if (col_kind != K_NONE) begin
      if (acc.kind == K_NONE) begin
        merged.kind = col_kind;
        merged.code = col_code;
      end else begin
        merged.kind = K_MULTI;
        if (col_code < acc.code) merged.code = col_code;
      end
    end
  end

  // A MULTI result matches any other MULTI; the tracked lowest code is informational only.
  always_comb begin
    same    = (merged.kind == cand.kind) &&
              ((merged.kind != K_SINGLE) || (merged.code == cand.code));
    cand_d  = merged;
    match_d = same ? ((match_cnt == MW'(DEBOUNCE)) ? match_cnt : match_cnt + MW'(1))
                   : MW'(1);
    differs = (cand_d.kind != state) ||
              ((cand_d.kind == K_SINGLE) && (cand_d.code != code_q));
    accept  = frame_end && (match_d == MW'(DEBOUNCE)) && differs;
  end

  // NOTE: sequential state is written with non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1     <= {N_ROWS{ACTIVE_LOW}};
      sync2     <= {N_ROWS{ACTIVE_LOW}};
      div       <= '0;
      col       <= '0;
      acc       <= '0;
      cand      <= '0;
      match_cnt <= '0;
    end else begin
      sync1 <= rows;
      sync2 <= sync1;
      if (sample) begin
        div <= '0;
        col <= (col == COLW'(N_COLS - 1)) ? '0 : col + COLW'(1);
        acc <= frame_end ? '0 : merged;
      end else begin
        div <= div + DW'(1);
      end
      if (frame_end) begin
        cand      <= cand_d;
        match_cnt <= match_d;
      end
    end
  end

  always_comb begin
    state_d     = state;
    code_d      = code_q;
    valid_d     = 1'b0;
    release_d   = 1'b0;
    rpt_d       = rpt;
    rpt_phase_d = rpt_phase;
    if (accept) begin
      state_d   = cand_d.kind;
      release_d = (state == K_SINGLE);
      if (cand_d.kind == K_SINGLE) begin
        code_d      = cand_d.code;
        valid_d     = 1'b1;
        rpt_d       = '0;
        rpt_phase_d = 1'b0;
      end
    end else if (REPEAT_EN && frame_end && (state == K_SINGLE)) begin
      // rpt counts frames since entry until the first repeat, then frames since the last one.
      rpt_d = rpt + RW'(1);
      if ((!rpt_phase && (rpt_d == RW'(REPEAT_DELAY))) ||
          ( rpt_phase && (rpt_d == RW'(REPEAT_RATE)))) begin
        valid_d     = 1'b1;
        rpt_d       = '0;
        rpt_phase_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= K_NONE;
      code_q    <= '0;
      valid_q   <= 1'b0;
      release_q <= 1'b0;
      rpt       <= '0;
      rpt_phase <= 1'b0;
    end else begin
      state     <= state_d;
      code_q    <= code_d;
      valid_q   <= valid_d;
      release_q <= release_d;
      rpt       <= rpt_d;
      rpt_phase <= rpt_phase_d;
    end
  end

  logic [N_COLS-1:0] col_onehot;
  assign col_onehot  = {{(N_COLS-1){1'b0}}, 1'b1} << col;
  assign cols        = ACTIVE_LOW ? ~col_onehot : col_onehot;
  assign key_code    = code_q;
  assign key_valid   = valid_q;
  assign key_release = release_q;
  assign key_held    = (state == K_SINGLE);
  assign key_multi   = (state == K_MULTI);

endmodule

// File: tb/tb_keypad_scanner.sv
// Frame-level bench: a table of per-frame key sets with the outputs expected after each
// frame end, run against a non-repeating scanner and an auto-repeating twin in lockstep.
module tb_keypad_scanner;

  typedef enum int {OP_FRAME, OP_COLS, OP_RST_MID} op_e;

  typedef struct {
    op_e         op;
    logic [15:0] keys;
    logic        valid;
    logic        rvalid;
    logic        rel;
    logic        held;
    logic        multi;
    logic [3:0]  code;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] keys;
  logic [3:0]  rows, cols, key_code;
  logic        key_valid, key_release, key_held, key_multi;
  logic [3:0]  rows_r, cols_r, code_r;
  logic        valid_r, release_r, held_r, multi_r;

  int n_checks = 0;
  int n_fail   = 0;
  int n_valid  = 0;
  int n_rvalid = 0;
  int n_rel    = 0;

  vec_t tbl[$];
  vec_t exp_q[$];

  always #5 clk = ~clk;

  keypad_scanner #(
    .N_ROWS(4), .N_COLS(4), .SCAN_DIV(4), .DEBOUNCE(3), .ACTIVE_LOW(1'b1),
    .REPEAT_EN(1'b0), .REPEAT_DELAY(8), .REPEAT_RATE(2)
  ) dut (
    .clk(clk), .rst(rst), .rows(rows), .cols(cols), .key_code(key_code),
    .key_valid(key_valid), .key_release(key_release), .key_held(key_held),
    .key_multi(key_multi)
  );

  keypad_scanner #(
    .N_ROWS(4), .N_COLS(4), .SCAN_DIV(4), .DEBOUNCE(3), .ACTIVE_LOW(1'b1),
    .REPEAT_EN(1'b1), .REPEAT_DELAY(8), .REPEAT_RATE(2)
  ) dut_rpt (
    .clk(clk), .rst(rst), .rows(rows_r), .cols(cols_r), .key_code(code_r),
    .key_valid(valid_r), .key_release(release_r), .key_held(held_r),
    .key_multi(multi_r)
  );

  // Pressed key (r,c) pulls row r low while column c is driven low.
  function automatic logic [3:0] pad(input logic [15:0] k, input logic [3:0] c);
    logic [3:0] r;
    r = 4'b1111;
    for (int rr = 0; rr < 4; rr++)
      for (int cc = 0; cc < 4; cc++)
        if (k[rr*4+cc] && !c[cc]) r[rr] = 1'b0;
    return r;
  endfunction

  always_comb rows   = pad(keys, cols);
  always_comb rows_r = pad(keys, cols_r);

  always @(negedge clk) begin
    if (key_valid)   n_valid++;
    if (valid_r)     n_rvalid++;
    if (key_release) n_rel++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input int n, input op_e op, input logic [15:0] k, input logic v,
                     input logic rv, input logic rl, input logic h, input logic m,
                     input logic [3:0] c);
    vec_t e;
    e.op = op; e.keys = k; e.valid = v; e.rvalid = rv; e.rel = rl;
    e.held = h; e.multi = m; e.code = c;
    for (int i = 0; i < n; i++) tbl.push_back(e);
  endtask

  task automatic check_outputs(input string tag, input vec_t e);
    check({tag, " key_valid"},   key_valid,   e.valid);
    check({tag, " repeat"},      valid_r,     e.rvalid);
    check({tag, " key_release"}, key_release, e.rel);
    check({tag, " key_held"},    key_held,    e.held);
    check({tag, " key_multi"},   key_multi,   e.multi);
    check({tag, " key_code"},    key_code,    e.code);
    check({tag, " rpt_code"},    code_r,      e.code);
  endtask

  localparam logic [15:0] K3 = 16'h0008, K5 = 16'h0020, K6 = 16'h0040, K9 = 16'h0200;
  localparam logic [15:0] K10 = 16'h0400, K12 = 16'h1000, K15 = 16'h8000;

  initial begin
    int exp_valid, exp_rvalid, exp_rel;
    vec_t v, e;
    logic [3:0] ec;

    // op, keys, valid, repeat-valid, release, held, multi, code
    add(4, OP_COLS,  16'h0, 0, 0, 0, 0, 0, 0);           // idle
    add(2, OP_FRAME, K9,    0, 0, 0, 0, 0, 0);           // press (2,1)
    add(1, OP_FRAME, K9,    1, 1, 0, 1, 0, 9);
    add(7, OP_FRAME, K9,    0, 0, 0, 1, 0, 9);
    add(1, OP_FRAME, 16'h0, 0, 1, 0, 1, 0, 9);           // twin repeats 8 frames after entry
    add(1, OP_FRAME, 16'h0, 0, 0, 0, 1, 0, 9);
    add(1, OP_FRAME, 16'h0, 0, 0, 1, 0, 0, 9);
    add(1, OP_FRAME, 16'h0, 0, 0, 0, 0, 0, 9);
    for (int i = 0; i < 3; i++) begin                     // bounce (0,3)
      add(1, OP_FRAME, K3,    0, 0, 0, 0, 0, 9);
      add(1, OP_FRAME, 16'h0, 0, 0, 0, 0, 0, 9);
    end
    add(2, OP_FRAME, K3,    0, 0, 0, 0, 0, 9);
    add(1, OP_FRAME, K3,    1, 1, 0, 1, 0, 3);
    add(1, OP_FRAME, K3,    0, 0, 0, 1, 0, 3);
    add(2, OP_FRAME, 16'h0, 0, 0, 0, 1, 0, 3);
    add(1, OP_FRAME, 16'h0, 0, 0, 1, 0, 0, 3);
    add(1, OP_FRAME, 16'h0, 0, 0, 0, 0, 0, 3);
    add(2, OP_FRAME, K5,      0, 0, 0, 0, 0, 3);         // multi-key
    add(1, OP_FRAME, K5,      1, 1, 0, 1, 0, 5);
    add(2, OP_FRAME, K5|K12,  0, 0, 0, 1, 0, 5);
    add(1, OP_FRAME, K5|K12,  0, 0, 1, 0, 1, 5);
    add(1, OP_FRAME, K5|K12,  0, 0, 0, 0, 1, 5);
    add(2, OP_FRAME, K5,      0, 0, 0, 0, 1, 5);
    add(1, OP_FRAME, K5,      1, 1, 0, 1, 0, 5);
    add(2, OP_FRAME, K6,      0, 0, 0, 1, 0, 5);         // direct change of key
    add(1, OP_FRAME, K6,      1, 1, 1, 1, 0, 6);
    add(2, OP_FRAME, 16'h0,   0, 0, 0, 1, 0, 6);
    add(1, OP_FRAME, 16'h0,   0, 0, 1, 0, 0, 6);
    add(1, OP_FRAME, 16'h0,   0, 0, 0, 0, 0, 6);
    add(2, OP_FRAME, K15,     0, 0, 0, 0, 0, 6);         // auto-repeat (3,3)
    add(1, OP_FRAME, K15,     1, 1, 0, 1, 0, 15);
    for (int k = 1; k <= 17; k++)
      add(1, OP_FRAME, K15, 0, (k >= 8) && (k % 2 == 0), 0, 1, 0, 15);
    add(1, OP_FRAME, 16'h0,   0, 1, 0, 1, 0, 15);
    add(1, OP_FRAME, 16'h0,   0, 0, 0, 1, 0, 15);
    add(1, OP_FRAME, 16'h0,   0, 0, 1, 0, 0, 15);
    add(1, OP_FRAME, 16'h0,   0, 0, 0, 0, 0, 15);
    add(2, OP_FRAME, K10,     0, 0, 0, 0, 0, 15);        // reset mid-hold (2,2)
    add(1, OP_FRAME, K10,     1, 1, 0, 1, 0, 10);
    add(1, OP_FRAME, K10,     0, 0, 0, 1, 0, 10);
    add(1, OP_RST_MID, K10,   0, 0, 0, 0, 0, 0);
    add(2, OP_FRAME, K10,     0, 0, 0, 0, 0, 0);
    add(1, OP_FRAME, K10,     1, 1, 0, 1, 0, 10);
    add(2, OP_FRAME, 16'h0,   0, 0, 0, 1, 0, 10);
    add(1, OP_FRAME, 16'h0,   0, 0, 1, 0, 0, 10);
    add(1, OP_FRAME, 16'h0,   0, 0, 0, 0, 0, 10);

    exp_valid = 0; exp_rvalid = 0; exp_rel = 0;
    foreach (tbl[i]) begin
      exp_valid  += int'(tbl[i].valid);
      exp_rvalid += int'(tbl[i].rvalid);
      exp_rel    += int'(tbl[i].rel);
    end

    rst  = 1'b1;
    keys = 16'h0;
    repeat (3) @(negedge clk);
    e = '{OP_FRAME, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0};
    check_outputs("reset", e);
    check("reset cols", cols, 4'b1110);
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      v    = tbl[i];
      keys = v.keys;
      if (v.op == OP_RST_MID) begin
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_outputs($sformatf("f%0d midrst", i), v);
        check($sformatf("f%0d midrst cols", i), cols, 4'b1110);
        rst = 1'b0;
      end else begin
        exp_q.push_back(v);
        for (int k = 0; k < 16; k++) begin
          if (v.op == OP_COLS) begin
            ec = ~(4'b0001 << (k / 4));
            check($sformatf("f%0d c%0d cols", i, k), cols, ec);
          end
          @(negedge clk);
        end
        e = exp_q.pop_front();
        check_outputs($sformatf("f%0d", i), e);
      end
    end

    @(negedge clk);
    check("key_valid pulse count", n_valid,  exp_valid);
    check("repeat pulse count",    n_rvalid, exp_rvalid);
    check("key_release pulse count", n_rel,  exp_rel);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run still active at %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
